// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - instruction-memory write bus between loader and imem
interface uart_prog_loader_if;
   logic        imem_we;
   logic [10:0] imem_waddr;
   logic [31:0] imem_wdata;

   modport master (output imem_we, output imem_waddr, output imem_wdata);
   modport slave  (input  imem_we, input  imem_waddr, input  imem_wdata);
endinterface

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART program downloader writing 32-bit words into instruction memory
module uart_prog_loader #(
   parameter int BAUD_DIV  = 87,
   parameter int MAX_WORDS = 2048
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                prog_en,
   input  logic                rx,
   output logic                tx,
   uart_prog_loader_if.master  imem,
   output logic                cpu_hold,
   output logic                load_done,
   output logic                load_err
);
   localparam int            CW       = $clog2(BAUD_DIV + 1);
   localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
   localparam logic [16:0]   MAXW     = 17'(MAX_WORDS);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERR} ld_state_t;

   // rx_m/rx_s form the synchronizer; rx_d is the previous synchronized value for edge detection
   logic rx_m, rx_s, rx_d;

   // Synchronize the asynchronous rx line; flops idle high so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   rx_state_t     r_state, r_next;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tick, byte_valid, frame_err;

   assign r_tick = (r_cnt == BIT_END);

   // Receiver state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_next;
   end

   // Receiver next state: start bit is re-checked at mid-bit to reject glitches
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (rx_d && !rx_s) r_next = R_START;
         R_START: if (r_cnt == HALF_END) r_next = rx_s ? R_IDLE : R_DATA;
         R_DATA:  if (r_tick && r_bit == 3'd7) r_next = R_STOP;
         R_STOP:  if (r_tick) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Receiver outputs: one-cycle strobes at the stop-bit sample
   always_comb begin
      byte_valid = (r_state == R_STOP) && r_tick && rx_s;
      frame_err  = (r_state == R_STOP) && r_tick && !rx_s;
   end

   // Receiver bit timing and LSB-first shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         if (r_state == R_IDLE || r_next != r_state || r_tick) r_cnt <= '0;
         else                                                   r_cnt <= r_cnt + CW'(1);
         if (r_state == R_IDLE) r_bit <= '0;
         if (r_state == R_DATA && r_tick) begin
            r_shift <= {rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
         end
      end
   end

   ld_state_t   state, next;
   logic [15:0] n_words, w_cnt, len_full;
   logic [1:0]  b_cnt;
   logic [23:0] w_buf;
   logic [10:0] addr;
   logic [31:0] wdata_q;
   logic        we_q, take;
   logic        hold_next, enter_len0, enter_done, enter_err, write_fire;

   // A byte arriving while prog_en is low is dropped: abort wins
   assign take     = byte_valid && prog_en;
   assign len_full = {r_shift, n_words[7:0]};

   // Loader state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next;
   end

   // Loader next state
   always_comb begin
      next = state;
      case (state)
         IDLE: if (prog_en) next = LEN0;
         LEN0: begin
            if (!prog_en || frame_err) next = ERR;
            else if (take)             next = LEN1;
         end
         LEN1: begin
            if (!prog_en || frame_err) next = ERR;
            else if (take)
               next = (len_full == 16'd0 || {1'b0, len_full} > MAXW) ? ERR : DATA;
         end
         DATA: begin
            if (!prog_en || frame_err)                  next = ERR;
            else if (we_q && (w_cnt + 16'd1 == n_words)) next = DONE;
         end
         DONE: if (!prog_en) next = IDLE;
         ERR:  if (!prog_en) next = IDLE;
         default: next = IDLE;
      endcase
   end

   // Loader decodes: transition strobes and the registered-output next values
   always_comb begin
      hold_next  = (next == LEN0) || (next == LEN1) || (next == DATA) || (next == ERR);
      enter_len0 = (state == IDLE) && (next == LEN0);
      enter_done = (state != DONE) && (next == DONE);
      enter_err  = (state != ERR)  && (next == ERR);
      write_fire = (state == DATA) && (next == DATA) && take && (b_cnt == 2'd3);
   end

   // Loader datapath: length capture, word assembly, write strobe and status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_hold  <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         addr      <= '0;
         w_cnt     <= '0;
         n_words   <= '0;
         b_cnt     <= '0;
         w_buf     <= '0;
      end else begin
         cpu_hold <= hold_next;
         we_q     <= write_fire;
         if (we_q) begin
            addr  <= addr + 11'd1;
            w_cnt <= w_cnt + 16'd1;
         end
         if (enter_len0) begin
            load_done <= 1'b0;
            load_err  <= 1'b0;
            addr      <= '0;
            w_cnt     <= '0;
            b_cnt     <= '0;
         end
         if (state == LEN0 && take) n_words[7:0]  <= r_shift;
         if (state == LEN1 && take) n_words[15:8] <= r_shift;
         if (state == DATA && next == DATA && take) begin
            case (b_cnt)
               2'd0:    w_buf[7:0]   <= r_shift;
               2'd1:    w_buf[15:8]  <= r_shift;
               2'd2:    w_buf[23:16] <= r_shift;
               default: w_buf        <= w_buf;
            endcase
            b_cnt <= b_cnt + 2'd1;
         end
         if (write_fire) wdata_q <= {r_shift, w_buf};
         if (enter_done) load_done <= 1'b1;
         if (enter_err)  load_err  <= 1'b1;
      end
   end

   assign imem.imem_we    = we_q;
   assign imem.imem_waddr = addr;
   assign imem.imem_wdata = wdata_q;

   logic          tx_busy, tx_q;
   logic [CW-1:0] t_cnt;
   logic [3:0]    t_left;
   logic [8:0]    t_shift;

   // Ack transmitter: start bit then 9 shifts (8 data + stop); requests while busy are dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_busy <= 1'b0;
         tx_q    <= 1'b1;
         t_cnt   <= '0;
         t_left  <= '0;
         t_shift <= '0;
      end else if (!tx_busy) begin
         if (enter_done || enter_err) begin
            tx_busy <= 1'b1;
            tx_q    <= 1'b0;
            t_shift <= {1'b1, (enter_done ? 8'h4F : 8'h45)};
            t_left  <= 4'd9;
            t_cnt   <= '0;
         end
      end else if (t_cnt == BIT_END) begin
         t_cnt <= '0;
         if (t_left == 4'd0) tx_busy <= 1'b0;
         else begin
            tx_q    <= t_shift[0];
            t_shift <= {1'b0, t_shift[8:1]};
            t_left  <= t_left - 4'd1;
         end
      end else begin
         t_cnt <= t_cnt + CW'(1);
      end
   end

   assign tx = tx_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - scoreboard bench for the UART program loader
module tb_uart_prog_loader;
   localparam int BD = 4;

   logic clk = 1'b0;
   logic rst, prog_en, rx;
   logic tx, cpu_hold, load_done, load_err;

   uart_prog_loader_if bus();

   uart_prog_loader #(.BAUD_DIV(BD), .MAX_WORDS(2048)) dut (
      .clk       (clk),
      .rst       (rst),
      .prog_en   (prog_en),
      .rx        (rx),
      .tx        (tx),
      .imem      (bus),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [42:0] exp_wr[$];
   logic [7:0]  exp_tx[$];
   logic        wr_prev = 1'b0;
   logic [7:0]  tx_b;
   logic [42:0] wr_e;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      tick(BD);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(BD);
      end
      rx = stop_bit;
      tick(BD);
      rx = 1'b1;
      tick(3);
   endtask

   // Write monitor: every imem_we pulse is compared against the expected-write queue
   initial begin
      forever begin
         @(negedge clk);
         if (bus.imem_we === 1'b1) begin
            check1("we_single_cycle", wr_prev, 1'b0);
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                        bus.imem_waddr, bus.imem_wdata);
            end else begin
               wr_e = exp_wr.pop_front();
               check32("wr_addr", {21'd0, bus.imem_waddr}, {21'd0, wr_e[42:32]});
               check32("wr_data", bus.imem_wdata, wr_e[31:0]);
            end
         end
         wr_prev = bus.imem_we;
      end
   end

   // Tx monitor: decode each 8N1 frame at mid-bit and compare with the expected-ack queue
   initial begin
      forever begin
         @(negedge clk);
         if (tx === 1'b0 && rst === 1'b0) begin
            repeat (2) @(negedge clk);
            check1("tx_start", tx, 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (BD) @(negedge clk);
               tx_b[i] = tx;
            end
            repeat (BD) @(negedge clk);
            check1("tx_stop", tx, 1'b1);
            if (exp_tx.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_tx: byte 0x%0h, expected none", tx_b);
            end else begin
               check32("tx_byte", {24'd0, tx_b}, {24'd0, exp_tx.pop_front()});
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      prog_en = 1'b0;
      rx = 1'b1;
      tick(3);
      check1("rst_tx", tx, 1'b1);
      check1("rst_we", bus.imem_we, 1'b0);
      check32("rst_waddr", {21'd0, bus.imem_waddr}, 32'd0);
      check32("rst_wdata", bus.imem_wdata, 32'd0);
      check1("rst_hold", cpu_hold, 1'b0);
      check1("rst_done", load_done, 1'b0);
      check1("rst_err", load_err, 1'b0);
      rst = 1'b0;
      tick(5);

      // Two-word download
      prog_en = 1'b1;
      tick(4);
      check1("hold_in_len0", cpu_hold, 1'b1);
      exp_wr.push_back({11'd0, 32'h12345678});
      exp_wr.push_back({11'd1, 32'hDEADBEEF});
      exp_tx.push_back(8'h4F);
      send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
      send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
      send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
      tick(80);
      check1("ok_done", load_done, 1'b1);
      check1("ok_err", load_err, 1'b0);
      check1("ok_hold", cpu_hold, 1'b0);
      prog_en = 1'b0;
      tick(4);
      check1("idle_done_held", load_done, 1'b1);
      check1("idle_hold", cpu_hold, 1'b0);

      // Zero length
      prog_en = 1'b1;
      tick(2);
      exp_tx.push_back(8'h45);
      send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      tick(60);
      check1("zero_err", load_err, 1'b1);
      check1("zero_done", load_done, 1'b0);
      check1("zero_hold", cpu_hold, 1'b1);
      prog_en = 1'b0;
      tick(3);
      check1("zero_idle_hold", cpu_hold, 1'b0);
      check1("zero_err_held", load_err, 1'b1);

      // Framing error on a data byte
      prog_en = 1'b1;
      tick(2);
      exp_tx.push_back(8'h45);
      send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b0);
      tick(60);
      check1("ferr_err", load_err, 1'b1);
      check1("ferr_hold", cpu_hold, 1'b1);
      prog_en = 1'b0;
      tick(3);

      // Abort after two data bytes, then a clean restart from address 0
      prog_en = 1'b1;
      tick(2);
      exp_tx.push_back(8'h45);
      send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
      prog_en = 1'b0;
      tick(60);
      check1("abort_err", load_err, 1'b1);
      check1("abort_hold", cpu_hold, 1'b0);
      send_byte(8'h05, 1'b1);
      tick(5);
      prog_en = 1'b1;
      tick(3);
      check1("len0_clears_err", load_err, 1'b0);
      exp_wr.push_back({11'd0, 32'h44332211});
      exp_tx.push_back(8'h4F);
      send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
      tick(60);
      check1("restart_done", load_done, 1'b1);
      prog_en = 1'b0;
      tick(3);

      // Glitch filtering, then an over-length request
      prog_en = 1'b1;
      tick(2);
      rx = 1'b0;
      tick(1);
      rx = 1'b1;
      tick(10);
      exp_tx.push_back(8'h45);
      send_byte(8'h01, 1'b1); send_byte(8'h08, 1'b1);
      tick(60);
      check1("big_err", load_err, 1'b1);
      check1("big_done", load_done, 1'b0);
      prog_en = 1'b0;
      tick(3);

      // Reset in the middle of DATA
      prog_en = 1'b1;
      tick(2);
      exp_wr.push_back({11'd0, 32'h04030201});
      send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
      send_byte(8'h05, 1'b1); send_byte(8'h06, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check1("mid_rst_tx", tx, 1'b1);
      check1("mid_rst_we", bus.imem_we, 1'b0);
      check32("mid_rst_waddr", {21'd0, bus.imem_waddr}, 32'd0);
      check32("mid_rst_wdata", bus.imem_wdata, 32'd0);
      check1("mid_rst_hold", cpu_hold, 1'b0);
      check1("mid_rst_done", load_done, 1'b0);
      check1("mid_rst_err", load_err, 1'b0);
      prog_en = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(60);
      check1("post_rst_hold", cpu_hold, 1'b0);
      check1("post_rst_done", load_done, 1'b0);

      check32("wr_queue_empty", exp_wr.size(), 32'd0);
      check32("tx_queue_empty", exp_tx.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
